// File: rtl/booth2_arbiter.sv
// Round-robin front end that time-shares one 16x16 signed multiplier between NUM_REQ requesters,
// with a watchdog that turns a stuck busy handshake into an error response.
module booth2_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned ARM_MAX = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [16*NUM_REQ-1:0]   i_req_x,
    input  logic [16*NUM_REQ-1:0]   i_req_y,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [31:0]             o_rsp_z,
    output logic                    o_rsp_err,
    output logic                    o_mul_start,
    output logic [15:0]             o_mul_x,
    output logic [15:0]             o_mul_y,
    input  logic                    i_mul_busy,
    input  logic [31:0]             i_mul_z
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned WD_MAX = (ARM_MAX > TIMEOUT) ? ARM_MAX : TIMEOUT;
    localparam int unsigned WD_W   = $clog2(WD_MAX + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StArm, StRun, StResp} state_e;

    state_e            r_state;
    logic [ID_W-1:0]   r_rr_last;
    logic [ID_W-1:0]   r_cur_id;
    logic [WD_W-1:0]   r_wd;
    logic              r_mul_start;
    logic [15:0]       r_mul_x;
    logic [15:0]       r_mul_y;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [31:0]       r_rsp_z;
    logic              r_rsp_err;

    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic [IDX_W-1:0]  w_idx;

    // Search starts one past the last grant and wraps, so the last winner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_idx = IDX_W'((int'(r_rr_last) + k) % int'(NUM_REQ));
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (r_state == StIdle && w_found) begin
            o_req_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_rr_last   <= ID_W'(NUM_REQ - 1);
            r_cur_id    <= '0;
            r_wd        <= '0;
            r_mul_start <= 1'b0;
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_z     <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_mul_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_mul_x     <= i_req_x[{w_win, 4'b0000} +: 16];
                        r_mul_y     <= i_req_y[{w_win, 4'b0000} +: 16];
                        r_cur_id    <= ID_W'(w_win);
                        r_rr_last   <= ID_W'(w_win);
                        r_mul_start <= 1'b1;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    r_wd    <= '0;
                    r_state <= StArm;
                end
                StArm: begin
                    if (i_mul_busy) begin
                        r_wd    <= '0;
                        r_state <= StRun;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                        if (r_wd == WD_W'(ARM_MAX - 1)) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_z     <= '0;
                            r_rsp_id    <= r_cur_id;
                            r_rsp_valid <= 1'b1;
                            r_state     <= StResp;
                        end
                    end
                end
                StRun: begin
                    if (!i_mul_busy) begin
                        r_rsp_err   <= 1'b0;
                        r_rsp_z     <= i_mul_z;
                        r_rsp_id    <= r_cur_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                        if (r_wd == WD_W'(TIMEOUT - 1)) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_z     <= '0;
                            r_rsp_id    <= r_cur_id;
                            r_rsp_valid <= 1'b1;
                            r_state     <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_mul_start = r_mul_start;
    assign o_mul_x     = r_mul_x;
    assign o_mul_y     = r_mul_y;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_z     = r_rsp_z;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: doc/booth2_arbiter.md
Name: booth2_arbiter

Overview:
- Round-robin scheduler that shares one radix-4 Booth multiplier (16x16 signed, start/busy/z interface) between NUM_REQ requesters.
- Accepts one operand pair at a time over a valid/ready handshake, sequences the multiplier's start pulse, and tracks its busy window.
- Captures the 32-bit product and returns it, tagged with the requester id, on a single valid/ready response port.
- Includes a watchdog so a stuck multiplier cannot hang the arbiter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; NUM_REQ <= 2**ID_W is required.
- ARM_MAX, 2, cycles allowed in ARM for mul_busy to rise before error.
- TIMEOUT, 16, cycles allowed in RUN for mul_busy to fall before error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_x  in  16*NUM_REQ  signed multiplicand; requester i uses bits [16i+15:16i].
- req_y  in  16*NUM_REQ  signed multiplier operand, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_z  out  32  signed product.
- rsp_err  out  1  watchdog error flag; rsp_z=0 when set.
- mul_start  out  1  one-cycle start to the multiplier.
- mul_x  out  16  operand x to the multiplier.
- mul_y  out  16  operand y to the multiplier.
- mul_busy  in  1  multiplier busy.
- mul_z  in  32  multiplier product.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rr_last=NUM_REQ-1, so requester 0 has first priority.
  - mul_start=0, mul_x=0, mul_y=0.
  - rsp_valid=0, rsp_id=0, rsp_z=0, rsp_err=0.
  - watchdog=0.
  - A reset during any state aborts the operation; no response is produced. The multiplier shares rst_n.
- Grant:
  - Round-robin search begins at index rr_last+1 and wraps modulo NUM_REQ; the first asserted req_valid wins.
  - req_ready is combinational and high only for the winner, and only while state=IDLE.
- IDLE:
  - If any req_valid=1, the handshake completes this cycle.
  - At the clock edge: latch the winner's x into mul_x, y into mul_y, its index into cur_id and rr_last; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mul_start=1 as a registered output, high only in this state.
  - Go to ARM; clear watchdog.
  - mul_x/mul_y hold their latched values from IDLE until the next grant.
- ARM:
  - If mul_busy=1, go to RUN and clear watchdog.
  - Otherwise increment watchdog. When watchdog reaches ARM_MAX, set rsp_err=1, rsp_z=0, rsp_id=cur_id, and go to RESP.
- RUN:
  - If mul_busy=0, capture rsp_z<=mul_z, rsp_err<=0, rsp_id<=cur_id, and go to RESP.
  - Otherwise increment watchdog. At TIMEOUT, take the error path as in ARM.
- RESP:
  - rsp_valid=1; rsp_id, rsp_z and rsp_err stay stable until rsp_ready=1.
  - On the accepting edge: rsp_valid<=0, go to IDLE.
  - There is no IDLE bypass, so a new grant happens no earlier than the cycle after acceptance.
- Latency with the companion multiplier (busy high for 9 cycles starting the cycle after start):
  - c0 = accept; c1 = ISSUE; c2 = ARM (sees busy=1); c3..c10 = RUN with busy high; c11 = RUN sees busy=0 and captures.
  - rsp_valid first high in c12.
  - With rsp_ready held high, the next accept is at c13, giving throughput of 1 product per 13 cycles.
- Arithmetic: products are 32-bit two's complement, passed through unmodified from mul_z; the arbiter does no arithmetic.
- Requester rules:
  - A requester with req_valid high and no grant must hold its operands.
  - The arbiter never accepts while a response is pending.
  - req_valid deasserted before grant is legal and is simply skipped.
- An unexpected mul_busy edge outside ARM/RUN is ignored.

Test Plan:
- Single op: req0 x=3, y=5 valid in c0 -> req_ready[0]=1 in c0; mul_start=1 only in c1; rsp_valid in c12 with rsp_id=0, rsp_z=32'h0000000F, rsp_err=0.
- Signed op: req1 x=-7 (16'hFFF9), y=6 -> rsp_id=1, rsp_z=32'hFFFFFFD6. Also x=16'h8000, y=16'h8000 -> rsp_z=32'h40000000.
- Fairness: req0 and req2 held valid continuously with rsp_ready=1 -> grants go 0, 2, 0, 2, with accepts 13 cycles apart. Adding req3 -> order 0, 2, 3, 0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_id/rsp_z stable, req_ready stays 0, mul_start stays 0. Raising rsp_ready -> accept, then IDLE next cycle.
- Watchdog: mul_busy tied 0 -> rsp_err=1, rsp_z=0 after ARM_MAX=2 ARM cycles. mul_busy tied 1 -> rsp_err=1 after TIMEOUT=16 RUN cycles. Both return to IDLE after rsp_ready.
- Reset mid-RUN: rst_n low in c6 -> all outputs at reset values immediately (async). After release, a new req0 x=2, y=2 -> rsp_z=4, rsp_id=0.
